// File: rtl/bp_profiler_pkg.sv
// Shared types and address offsets for the stall-attribution profiler.
package bp_profiler_pkg;

  typedef enum logic [4:0] {
    e_stall_unknown        = 5'd0,
    e_stall_fe_queue_stall = 5'd1,
    e_stall_fe_wait        = 5'd2,
    e_stall_itlb_miss      = 5'd3,
    e_stall_icache_miss    = 5'd4,
    e_stall_icache_fill    = 5'd5,
    e_stall_branch_ovr     = 5'd6,
    e_stall_ret_ovr        = 5'd7,
    e_stall_fe_cmd         = 5'd8,
    e_stall_fe_cmd_fence   = 5'd9,
    e_stall_mispredict     = 5'd10,
    e_stall_control_haz    = 5'd11,
    e_stall_long_haz       = 5'd12,
    e_stall_data_haz       = 5'd13,
    e_stall_aux_dep        = 5'd14,
    e_stall_load_dep       = 5'd15,
    e_stall_mul_dep        = 5'd16,
    e_stall_fma_dep        = 5'd17,
    e_stall_sb_full        = 5'd18,
    e_stall_l2_miss        = 5'd19,
    e_stall_dtlb_miss      = 5'd20,
    e_stall_dcache_miss    = 5'd21,
    e_stall_exception      = 5'd22,
    e_stall_eret           = 5'd23
  } bp_stall_reason_e;

  // Instr/cycle counters sit directly above the reason counters.
  localparam int unsigned instr_ctr_ofs_lp = 0;
  localparam int unsigned cycle_ctr_ofs_lp = 1;

  // Read response metadata; oob marks an address beyond the counter map.
  typedef struct packed {
    logic v;
    logic oob;
  } bp_prof_rd_resp_s;

endpackage

// File: rtl/bp_stall_attrib_pipe.sv
// Stall attribution shift pipe: per-stage events accumulate toward the tail,
// where the lowest set bit is picked as the cycle's stall reason.
module bp_stall_attrib_pipe
  import bp_profiler_pkg::*;
#(
  parameter int unsigned num_reasons_p = 24,
  parameter int unsigned num_stages_p  = 8,
  localparam int unsigned reason_width_lp = (num_reasons_p > 1) ? $clog2(num_reasons_p) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_li,
  input  logic [num_stages_p*num_reasons_p-1:0] i_evt,
  output logic [reason_width_lp-1:0]            o_reason_c,
  output logic                                  o_reason_v_c
);

  logic [num_stages_p-1:0][num_reasons_p-1:0] r_stage;
  logic [num_stages_p-1:0][num_reasons_p-1:0] w_stage_n;
  logic [num_reasons_p-1:0]                   w_tail;

  // Each stage inherits the previous stage's bits; stage 0 takes only new events.
  assign w_stage_n = {r_stage[num_stages_p-2:0], {num_reasons_p{1'b0}}} | i_evt;

  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      r_stage <= '0;
    end else begin
      r_stage <= w_stage_n;
    end
  end

  assign w_tail       = r_stage[num_stages_p-1];
  assign o_reason_v_c = |w_tail;

  // Lowest-index set bit wins.
  always_comb begin
    o_reason_c = '0;
    for (int i = int'(num_reasons_p) - 1; i >= 0; i--) begin
      if (w_tail[i]) o_reason_c = reason_width_lp'(i);
    end
  end

endmodule

// File: rtl/bp_stall_hist_profiler.sv
// Per-reason stall histogram counters with a 1-cycle read port.
// Optional shadow snapshot bank enabled by PROFILER_SNAPSHOT_EN.
module bp_stall_hist_profiler
  import bp_profiler_pkg::*;
#(
  parameter int unsigned num_reasons_p = 24,
  parameter int unsigned num_stages_p  = 8,
  parameter int unsigned ctr_width_p   = 32,
  localparam int unsigned addr_width_lp = $clog2(num_reasons_p + 2)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_li,
  input  logic                                  enable_i,
  input  logic                                  clear_i,
  input  logic                                  snap_i,
  input  logic [num_stages_p*num_reasons_p-1:0] evt_i,
  input  logic                                  instret_i,
  input  logic                                  rd_v_i,
  input  logic [addr_width_lp-1:0]              rd_addr_i,
  output logic                                  rd_v_o,
  output logic [ctr_width_p-1:0]                rd_data_o,
  output logic [num_reasons_p+1:0]              ovf_o
);

  localparam int unsigned num_ctrs_lp     = num_reasons_p + 2;
  localparam int unsigned instr_addr_lp   = num_reasons_p + instr_ctr_ofs_lp;
  localparam int unsigned cycle_addr_lp   = num_reasons_p + cycle_ctr_ofs_lp;
  localparam int unsigned reason_width_lp = (num_reasons_p > 1) ? $clog2(num_reasons_p) : 1;

  logic [reason_width_lp-1:0] w_reason;
  logic                       w_reason_v;
  logic [addr_width_lp-1:0]   w_rsn_sel;
  logic [num_ctrs_lp-1:0]     w_inc;

  logic [ctr_width_p-1:0]     r_ctr [num_ctrs_lp];
  logic [num_ctrs_lp-1:0]     r_ovf;
  logic [ctr_width_p-1:0]     w_rd_src [num_ctrs_lp];
  logic                       w_rd_oob;
  bp_prof_rd_resp_s           r_rd_resp;
  logic [ctr_width_p-1:0]     r_rd_data;

  bp_stall_attrib_pipe #(
    .num_reasons_p (num_reasons_p),
    .num_stages_p  (num_stages_p)
  ) u_pipe (
    .clk_i        (clk_i),
    .reset_li     (reset_li),
    .i_evt        (evt_i),
    .o_reason_c   (w_reason),
    .o_reason_v_c (w_reason_v)
  );

  // One-hot increment: cycle always, plus exactly one of instr or reason.
  always_comb begin
    w_rsn_sel = w_reason_v ? addr_width_lp'(w_reason) : addr_width_lp'(e_stall_unknown);
    w_inc     = '0;
    if (enable_i) begin
      w_inc[cycle_addr_lp] = 1'b1;
      if (instret_i) w_inc[instr_addr_lp] = 1'b1;
      else           w_inc[w_rsn_sel]     = 1'b1;
    end
  end

  // Saturating counters; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      r_ctr <= '{default: '0};
      r_ovf <= '0;
    end else if (clear_i) begin
      r_ctr <= '{default: '0};
      r_ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < num_ctrs_lp; i++) begin
        if (w_inc[i]) begin
          if (&r_ctr[i]) r_ovf[i] <= 1'b1;
          else           r_ctr[i] <= r_ctr[i] + ctr_width_p'(1);
        end
      end
    end
  end

`ifdef PROFILER_SNAPSHOT_EN
  logic [ctr_width_p-1:0] r_shadow [num_ctrs_lp];

  // Shadow captures pre-increment, pre-clear live values.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      r_shadow <= '{default: '0};
    end else if (snap_i) begin
      r_shadow <= r_ctr;
    end
  end

  assign w_rd_src = r_shadow;
`else
  logic w_unused_snap;
  assign w_unused_snap = snap_i;
  assign w_rd_src      = r_ctr;
`endif

  assign w_rd_oob = (32'(rd_addr_i) >= 32'(num_ctrs_lp));

  // Data only loads on in-range reads so it holds between requests.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      r_rd_resp <= '0;
      r_rd_data <= '0;
    end else begin
      r_rd_resp.v <= rd_v_i;
      if (rd_v_i) begin
        r_rd_resp.oob <= w_rd_oob;
        if (!w_rd_oob) r_rd_data <= w_rd_src[rd_addr_i];
      end
    end
  end

  assign rd_v_o    = r_rd_resp.v;
  assign rd_data_o = r_rd_resp.oob ? '0 : r_rd_data;
  assign ovf_o     = r_ovf;

endmodule
